mux_feed_arbiter: RTL

Upstream feeder for the 8-bit two-input `multiplexer` stage. Accepts bytes from two independent valid/ready producers into one-entry holding slots and round-robin arbitrates between them. Drives the multiplexer's `a`, `b` and `sel` inputs, holding the selection stable for a programmable number of cycles. Emits `x_valid`/`x_src` aligned with the multiplexer's registered output `x`.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_in_slot.sv | 48 ++++
 rtl/mux_feed_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the multiplexer feed path.
package mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_WIDTH = 8;
    localparam int HOLD_W    = 4;

endpackage

// File: rtl/mux_in_slot.sv
// One-entry holding slot: captures on handshake, frees on release.
module mux_in_slot
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             rel_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready = ~full_q;
    assign full_o   = full_q;
    assign data_o   = data_q;

    // Release only happens while full and capture only while empty,
    // so the two never coincide. Data is kept after release.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (rel_i) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/mux_feed_arbiter.sv
// Round-robin feeder for the two-input multiplexer with a held select
// and an x_valid/x_src flag aligned to the registered mux output.
module mux_feed_arbiter
    import mux_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             sel,
    output logic             x_valid,
    output logic             x_src
);

    localparam logic [HOLD_W-1:0] CNT_INIT = HOLD_W'(HOLD_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              xv_q, xv_d;
    logic              xs_q, xs_d;
    logic              a_full, b_full;
    logic              rel_a, rel_b;
    logic              grant_ch;

    mux_in_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .in_valid (a_valid),
        .in_data  (a_data),
        .in_ready (a_ready),
        .rel_i    (rel_a),
        .full_o   (a_full),
        .data_o   (a)
    );

    mux_in_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk      (sysclk),
        .rst_n    (rst_n),
        .in_valid (b_valid),
        .in_data  (b_data),
        .in_ready (b_ready),
        .rel_i    (rel_b),
        .full_o   (b_full),
        .data_o   (b)
    );

    // On a tie the channel not served last wins.
    assign grant_ch = (a_full && b_full) ? ~last_q :
                      (b_full ? SEL_B : SEL_A);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        xv_d    = 1'b0;
        xs_d    = xs_q;
        rel_a   = 1'b0;
        rel_b   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (a_full || b_full) begin
                    sel_d   = grant_ch;
                    cnt_d   = CNT_INIT;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else begin
                    rel_a   = (sel_q == SEL_A);
                    rel_b   = (sel_q == SEL_B);
                    last_d  = sel_q;
                    xv_d    = 1'b1;
                    xs_d    = sel_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_A;
            last_q  <= SEL_B;
            xv_q    <= 1'b0;
            xs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            xv_q    <= xv_d;
            xs_q    <= xs_d;
        end
    end

    assign sel     = sel_q;
    assign x_valid = xv_q;
    assign x_src   = xs_q;

endmodule
